// File: rtl/instr_encoder_loader_if.sv
// Field-beat stream carrying instruction fields into the encoder/loader.
// The producer is the master; the loader is the slave and drives in_ready.
interface instr_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [2:0]  in_fmt;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [19:0] in_imm;

    modport master (
        output in_valid, in_last, in_fmt, in_rd, in_rs1,
        output in_rs2, in_funct3, in_funct7, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_last, in_fmt, in_rd, in_rs1,
        input  in_rs2, in_funct3, in_funct7, in_imm,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes RV32I instruction fields and writes them sequentially to imem.
// Optional macro ENC_LUI_EN enables fmt 5 (LUI) encoding.
module instr_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    instr_encoder_loader_if.slave s,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_W:0]       count,
    output logic                  busy,
    output logic                  load_done,
    output logic                  err_fmt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [31:0] NOP = 32'h0000_0013;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                ready;
    logic [31:0]         enc;
    logic                bad_fmt;

    always_comb begin
        enc     = NOP;
        bad_fmt = 1'b0;
        case (s.in_fmt)
            3'd0: enc = {s.in_funct7, s.in_rs2, s.in_rs1,
                         s.in_funct3, s.in_rd, OP_R};
            3'd1: enc = {s.in_imm[11:0], s.in_rs1,
                         s.in_funct3, s.in_rd, OP_I};
            3'd2: enc = {s.in_imm[11:0], s.in_rs1,
                         s.in_funct3, s.in_rd, OP_L};
            3'd3: enc = {s.in_imm[11:5], s.in_rs2, s.in_rs1,
                         s.in_funct3, s.in_imm[4:0], OP_S};
            // in_imm holds offset[12:1], so bit k here is offset bit k+1
            3'd4: enc = {s.in_imm[11], s.in_imm[9:4], s.in_rs2,
                         s.in_rs1, s.in_funct3, s.in_imm[3:0],
                         s.in_imm[10], OP_B};
`ifdef ENC_LUI_EN
            3'd5: enc = {s.in_imm, s.in_rd, 7'b0110111};
`endif
            default: bad_fmt = 1'b1;
        endcase
    end

`ifndef ENC_LUI_EN
    logic unused_imm_hi;
    assign unused_imm_hi = ^s.in_imm[19:12];
`endif

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                ready = (count_q < DEPTH_C);
                if (ready && s.in_valid) begin
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    wdata_d = enc;
                    count_d = count_q + 1'b1;
                    if (bad_fmt) err_d = 1'b1;
                    if (s.in_last || count_d == DEPTH_C) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign s.in_ready  = ready;
    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign count       = count_q;
    assign err_fmt     = err_q;
    assign busy        = (state_q == LOAD) || (state_q == FLUSH);
    assign load_done   = (state_q == DONE);

endmodule
